// File: rtl/rs_stream_encoder.sv
// Systematic Reed-Solomon stream encoder.
// Message symbols pass through; parity follows from an LFSR.
module rs_stream_encoder #(
  parameter int EGF_DIM     = 8,
  parameter int EGF_POLY    = 'h11D,
  parameter int RSC_PAR_LEN = 16,
  parameter int RSC_COD_LEN = 255
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [EGF_DIM-1:0]                 in_data,
  input  logic                               in_last,
  input  logic [$clog2(RSC_COD_LEN+1)-1:0]   cfg_mes_len,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [EGF_DIM-1:0]                 out_data,
  output logic                               out_par,
  output logic                               out_last,
  output logic                               err_len
);

  localparam int P    = RSC_PAR_LEN;
  localparam int CW   = $clog2(RSC_COD_LEN+1);
  localparam int KMAX = RSC_COD_LEN - RSC_PAR_LEN;

  localparam logic [EGF_DIM:0] POLY = EGF_POLY[EGF_DIM:0];
  localparam logic [CW-1:0]    KMAX_W = CW'(KMAX);
  localparam logic [CW-1:0]    PLAST = CW'(P-1);
  localparam logic [CW-1:0]    ONE_W = CW'(1);

  typedef logic [EGF_DIM-1:0] sym_t;
  typedef sym_t [P:0] gpoly_t;
  typedef enum logic [1:0] {IDLE, MES, PAR} state_t;

  function automatic sym_t gmul(sym_t a, sym_t b);
    logic [EGF_DIM:0] t;
    sym_t p;
    sym_t x;
    p = '0;
    x = a;
    for (int i = 0; i < EGF_DIM; i++) begin
      if (b[i]) p = p ^ x;
      t = {x, 1'b0};
      if (t[EGF_DIM]) t = t ^ POLY;
      x = t[EGF_DIM-1:0];
    end
    return p;
  endfunction

  // g(x) = prod (x + alpha^i), built one root at a time
  function automatic gpoly_t gen_poly();
    gpoly_t g;
    sym_t r;
    g = '0;
    g[0] = sym_t'(1);
    r = sym_t'(1);
    for (int i = 0; i < P; i++) begin
      for (int j = P; j > 0; j--)
        g[j] = g[j-1] ^ gmul(g[j], r);
      g[0] = gmul(g[0], r);
      r = gmul(r, sym_t'(2));
    end
    return g;
  endfunction

  localparam gpoly_t GEN = gen_poly();

  state_t        state, state_nx;
  sym_t [P-1:0]  lfsr, lfsr_nx, lfsr_base;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic [CW-1:0] k_reg, k_nx, k_in, k_cur;
  sym_t          fb, od_nx;
  logic          ov_nx, op_nx, ol_nx, err_nx;
  logic          slot_free, in_fire, par_fire;
  logic          hit_k, end_mes;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = rst_n && (state != PAR) && slot_free;
  assign in_fire   = in_valid && in_ready;
  assign par_fire  = (state == PAR) && slot_free;

  // clamp the requested message length into 1..KMAX
  always_comb begin
    k_in = cfg_mes_len;
    if (cfg_mes_len == '0)
      k_in = ONE_W;
    else if (cfg_mes_len > KMAX_W)
      k_in = KMAX_W;
  end

  // next state, LFSR update and output slot loading
  always_comb begin
    state_nx  = state;
    lfsr_nx   = lfsr;
    cnt_nx    = cnt;
    k_nx      = k_reg;
    od_nx     = out_data;
    op_nx     = out_par;
    ol_nx     = out_last;
    ov_nx     = out_valid && !out_ready;
    err_nx    = 1'b0;
    k_cur     = (state == IDLE) ? k_in : k_reg;
    lfsr_base = (state == IDLE) ? '0 : lfsr;
    cnt_inc   = (state == IDLE) ? ONE_W : cnt + ONE_W;
    fb        = in_data ^ lfsr_base[P-1];
    hit_k     = (cnt_inc == k_cur);
    end_mes   = in_last || hit_k;
    if (in_fire) begin
      k_nx       = k_cur;
      lfsr_nx[0] = gmul(fb, GEN[0]);
      for (int i = 1; i < P; i++)
        lfsr_nx[i] = lfsr_base[i-1] ^ gmul(fb, GEN[i]);
      od_nx    = in_data;
      op_nx    = 1'b0;
      ol_nx    = 1'b0;
      ov_nx    = 1'b1;
      cnt_nx   = end_mes ? '0 : cnt_inc;
      state_nx = end_mes ? PAR : MES;
      err_nx   = end_mes && (in_last != hit_k);
    end else if (par_fire) begin
      od_nx = lfsr[P-1];
      op_nx = 1'b1;
      ol_nx = (cnt == PLAST);
      ov_nx = 1'b1;
      for (int i = 1; i < P; i++)
        lfsr_nx[i] = lfsr[i-1];
      lfsr_nx[0] = '0;
      cnt_nx = cnt + ONE_W;
      if (cnt == PLAST) begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr      <= '0;
      cnt       <= '0;
      k_reg     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_par   <= 1'b0;
      out_last  <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      lfsr      <= lfsr_nx;
      cnt       <= cnt_nx;
      k_reg     <= k_nx;
      out_valid <= ov_nx;
      out_data  <= od_nx;
      out_par   <= op_nx;
      out_last  <= ol_nx;
      err_len   <= err_nx;
    end
  end

endmodule

// File: tb/tb_rs_stream_encoder.sv
// Scoreboard bench for rs_stream_encoder.
// dut2 uses two parity symbols, dut16 the defaults.
module tb_rs_stream_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_n, in_valid, in_ready, in_last;
  logic [1:0] out_valid, out_ready, out_par, out_last, err_len;
  logic [7:0] in_data [2];
  logic [7:0] cfg [2];
  logic [7:0] out_data [2];

  rs_stream_encoder #(.RSC_PAR_LEN(2)) dut2 (
    .clk(clk), .rst_n(rst_n[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_last(in_last[0]),
    .cfg_mes_len(cfg[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_par(out_par[0]),
    .out_last(out_last[0]), .err_len(err_len[0])
  );

  rs_stream_encoder dut16 (
    .clk(clk), .rst_n(rst_n[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_last(in_last[1]),
    .cfg_mes_len(cfg[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_par(out_par[1]),
    .out_last(out_last[1]), .err_len(err_len[1])
  );

  logic [9:0] q0[$];
  logic [9:0] q1[$];
  int checks = 0;
  int failures = 0;
  int err_cnt [2];
  int par_seen [2];
  int outs [2];
  int first_x [2];
  int last_x [2];
  int cyc = 0;
  logic stall_p [2];
  logic [9:0] prev_o [2];
  logic [9:0] mcur, mexp;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  function automatic int qsize(int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void push(int d, logic [7:0] v, bit p, bit l);
    if (d == 0) q0.push_back({v, p, l});
    else        q1.push_back({v, p, l});
  endfunction

  // pre-edge sampling of the output side of both DUTs
  always @(negedge clk) begin
    #4;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n[d]) begin
        stall_p[d] = 1'b0;
        continue;
      end
      if (err_len[d]) err_cnt[d]++;
      mcur = {out_data[d], out_par[d], out_last[d]};
      if (stall_p[d]) begin
        chk("hold_valid", {31'd0, out_valid[d]}, 32'd1);
        chk("hold_data", {22'd0, mcur}, {22'd0, prev_o[d]});
      end
      stall_p[d] = out_valid[d] && !out_ready[d];
      prev_o[d] = mcur;
      if (out_valid[d] && out_ready[d]) begin
        outs[d]++;
        if (first_x[d] < 0) first_x[d] = cyc;
        last_x[d] = cyc;
        if (qsize(d) == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out dut=%0d actual=%0h required=none",
                   d, mcur);
        end else begin
          mexp = (d == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("out_dut%0d", d), {22'd0, mcur}, {22'd0, mexp});
          if (mcur[1]) par_seen[d]++;
        end
      end
    end
  end

  task automatic put(int d, logic [7:0] v, bit l, logic [7:0] k);
    int n;
    @(negedge clk); #1;
    in_valid[d] = 1'b1;
    in_data[d]  = v;
    in_last[d]  = l;
    cfg[d]      = k;
    #1;
    n = 0;
    while (!in_ready[d] && n < 300) begin
      @(negedge clk); #2;
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL in_accept_timeout dut=%0d actual=stuck required=accept", d);
    end
    @(posedge clk); #1;
  endtask

  task automatic msg(int d, logic [7:0] v, bit l, logic [7:0] k);
    push(d, v, 1'b0, 1'b0);
    put(d, v, l, k);
  endtask

  task automatic idle_in(int d);
    @(negedge clk); #1;
    in_valid[d] = 1'b0;
    in_last[d]  = 1'b0;
  endtask

  task automatic drain(int d);
    int n;
    n = 0;
    while ((qsize(d) != 0 || out_valid[d]) && n < 2000) begin
      @(negedge clk); #2;
      n++;
    end
    chk("drain_done", {31'd0, n < 2000}, 32'd1);
  endtask

  task automatic do_reset(int d);
    rst_n[d]    = 1'b0;
    in_valid[d] = 1'b0;
    in_last[d]  = 1'b0;
    if (d == 0) q0.delete();
    else        q1.delete();
    repeat (2) @(negedge clk);
    #2;
    chk("rst_in_ready", {31'd0, in_ready[d]}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid[d]}, 32'd0);
    chk("rst_out_data", {24'd0, out_data[d]}, 32'd0);
    chk("rst_out_par", {31'd0, out_par[d]}, 32'd0);
    chk("rst_out_last", {31'd0, out_last[d]}, 32'd0);
    chk("rst_err_len", {31'd0, err_len[d]}, 32'd0);
    @(negedge clk); #1;
    rst_n[d] = 1'b1;
    #1;
    chk("rst_release_ready", {31'd0, in_ready[d]}, 32'd1);
  endtask

  task automatic cw_basic();
    msg(0, 8'h01, 1'b1, 8'd1);
    push(0, 8'h03, 1'b1, 1'b0);
    push(0, 8'h02, 1'b1, 1'b1);
    idle_in(0);
    drain(0);
  endtask

  int base;
  int vcnt;
  int n;

  initial begin
    for (int d = 0; d < 2; d++) begin
      in_data[d] = '0;
      cfg[d] = '0;
      err_cnt[d] = 0;
      par_seen[d] = 0;
      outs[d] = 0;
      first_x[d] = -1;
      last_x[d] = 0;
      stall_p[d] = 1'b0;
      prev_o[d] = '0;
    end
    in_valid = '0;
    in_last = '0;
    out_ready = 2'b11;
    rst_n = '0;
    do_reset(0);
    do_reset(1);

    cw_basic();
    chk("err_basic", err_cnt[0], 0);

    msg(0, 8'h01, 1'b0, 8'd2);
    msg(0, 8'h00, 1'b1, 8'd2);
    push(0, 8'h07, 1'b1, 1'b0);
    push(0, 8'h06, 1'b1, 1'b1);
    idle_in(0);
    drain(0);

    msg(0, 8'h10, 1'b0, 8'd2);
    msg(0, 8'h20, 1'b1, 8'd2);
    push(0, 8'h10, 1'b1, 1'b0);
    push(0, 8'h20, 1'b1, 1'b1);
    idle_in(0);
    drain(0);
    chk("err_clean", err_cnt[0], 0);

    msg(0, 8'h80, 1'b1, 8'd0);
    push(0, 8'h9D, 1'b1, 1'b0);
    push(0, 8'h1D, 1'b1, 1'b1);
    idle_in(0);
    @(negedge clk); #1;
    out_ready[0] = 1'b0;
    repeat (5) begin
      @(negedge clk); #2;
      chk("stall_in_ready", {31'd0, in_ready[0]}, 32'd0);
    end
    out_ready[0] = 1'b1;
    drain(0);
    chk("err_k0_clamp", err_cnt[0], 0);

    msg(0, 8'h01, 1'b0, 8'd10);
    msg(0, 8'h00, 1'b0, 8'd10);
    msg(0, 8'h10, 1'b0, 8'd10);
    msg(0, 8'h20, 1'b1, 8'd10);
    push(0, 8'h0F, 1'b1, 1'b0);
    push(0, 8'h3E, 1'b1, 1'b1);
    idle_in(0);
    drain(0);
    chk("err_early_last", err_cnt[0], 1);

    msg(0, 8'h01, 1'b0, 8'd2);
    msg(0, 8'h00, 1'b0, 8'd2);
    push(0, 8'h07, 1'b1, 1'b0);
    push(0, 8'h06, 1'b1, 1'b1);
    idle_in(0);
    drain(0);
    chk("err_missing_last", err_cnt[0], 2);

    base = outs[0];
    first_x[0] = -1;
    msg(0, 8'h01, 1'b1, 8'd1);
    push(0, 8'h03, 1'b1, 1'b0);
    push(0, 8'h02, 1'b1, 1'b1);
    msg(0, 8'h01, 1'b0, 8'd2);
    msg(0, 8'h00, 1'b1, 8'd2);
    push(0, 8'h07, 1'b1, 1'b0);
    push(0, 8'h06, 1'b1, 1'b1);
    idle_in(0);
    drain(0);
    chk("b2b_count", outs[0] - base, 7);
    chk("b2b_span_ok",
        {31'd0, (last_x[0] - first_x[0] + 1) <= 8}, 32'd1);

    msg(0, 8'h55, 1'b0, 8'd5);
    msg(0, 8'h66, 1'b0, 8'd5);
    do_reset(0);
    cw_basic();
    chk("err_after_rst", err_cnt[0], 2);

    base = outs[1];
    for (int i = 0; i < 239; i++)
      msg(1, 8'h00, i == 238, 8'd239);
    for (int i = 0; i < 16; i++)
      push(1, 8'h00, 1'b1, i == 15);
    idle_in(1);
    drain(1);
    chk("zero_cw_count", outs[1] - base, 255);
    chk("zero_cw_err", err_cnt[1], 0);

    for (int i = 0; i < 3; i++)
      msg(1, 8'h00, i == 2, 8'd3);
    for (int i = 0; i < 16; i++)
      push(1, 8'h00, 1'b1, i == 15);
    idle_in(1);
    n = 0;
    while (par_seen[1] < 18 && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    chk("par_progress", {31'd0, n < 200}, 32'd1);
    do_reset(1);
    vcnt = 0;
    repeat (20) begin
      @(negedge clk); #2;
      if (out_valid[1]) vcnt++;
    end
    chk("no_residue", vcnt, 0);
    base = outs[1];
    msg(1, 8'h00, 1'b1, 8'd1);
    for (int i = 0; i < 16; i++)
      push(1, 8'h00, 1'b1, i == 15);
    idle_in(1);
    drain(1);
    chk("post_rst_count", outs[1] - base, 17);

    chk("q0_empty", qsize(0), 0);
    chk("q1_empty", qsize(1), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
